// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} fetch_state_t;

  localparam int INSN_W  = 32;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch/stall event counters, only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_fetch,
  input  logic        inc_stall,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (inc_fetch) fetch_cnt <= fetch_cnt + 32'd1;
      if (inc_stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, one outstanding req/gnt/rvalid access at a time.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
//
// state | meaning
// IDLE  | post-reset, request starts next cycle
// REQ   | mem_req asserted, waiting for gnt
// WAIT  | granted, waiting for rvalid (discard set if redirected meanwhile)
// OUT   | instruction presented to decode
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INSN_W-1:0] mem_rdata,
  output logic              if_valid,
  output logic [INSN_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, redir_al;
  logic              discard, discard_nxt;
  logic              valid_nxt;
  logic [INSN_W-1:0] inst_nxt;
  logic [ADDR_W-1:0] ifpc_nxt, ifpc4_nxt;

  assign redir_al = redirect_pc & ~ADDR_W'(3);
  assign pc_inc   = pc + ADDR_W'(PC_STEP);
  assign mem_addr = pc;
  assign mem_req  = (state == REQ);

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    valid_nxt   = if_valid;
    inst_nxt    = if_inst;
    ifpc_nxt    = if_pc;
    ifpc4_nxt   = if_pc4;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (mem_gnt && mem_rvalid) begin
          // zero-latency memory: behave as if the data arrived in WAIT
          if (redirect) begin
            pc_nxt = redir_al;
          end else begin
            inst_nxt  = mem_rdata;
            ifpc_nxt  = pc;
            ifpc4_nxt = pc_inc;
            pc_nxt    = pc_inc;
            valid_nxt = 1'b1;
            state_nxt = OUT;
          end
        end else if (mem_gnt) begin
          state_nxt = WAIT;
          if (redirect) begin
            discard_nxt = 1'b1;
            pc_nxt      = redir_al;
          end
        end else if (redirect) begin
          pc_nxt = redir_al;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_nxt   = REQ;
          discard_nxt = 1'b0;
          if (redirect) begin
            pc_nxt = redir_al;
          end else if (!discard) begin
            inst_nxt  = mem_rdata;
            ifpc_nxt  = pc;
            ifpc4_nxt = pc_inc;
            pc_nxt    = pc_inc;
            valid_nxt = 1'b1;
            state_nxt = OUT;
          end
        end else if (redirect) begin
          discard_nxt = 1'b1;
          pc_nxt      = redir_al;
        end
      end
      OUT: begin
        if (redirect) begin
          valid_nxt = 1'b0;
          pc_nxt    = redir_al;
          state_nxt = REQ;
        end else if (!stall) begin
          valid_nxt = 1'b0;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      discard  <= 1'b0;
      if_valid <= 1'b0;
      if_inst  <= '0;
      if_pc    <= '0;
      if_pc4   <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      discard  <= discard_nxt;
      if_valid <= valid_nxt;
      if_inst  <= inst_nxt;
      if_pc    <= ifpc_nxt;
      if_pc4   <= ifpc4_nxt;
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_cnt u_perf (
    .clk       (clk),
    .rst       (rst),
    .inc_fetch ((state == OUT) && !stall && !redirect),
    .inc_stall ((state == OUT) && stall && !redirect),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Directed self-checking bench for fetch_seq.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, mem_gnt, mem_rvalid;
  logic [31:0] redirect_pc, mem_rdata;
  logic        mem_req, if_valid;
  logic [31:0] mem_addr, if_inst, if_pc, if_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_seq #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_pc4(if_pc4)
`ifdef FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_inst !== 32'h0 || if_pc !== 32'h0 || if_pc4 !== 32'h0) begin
      n_err++; $display("FAIL reset_if: got %h/%h/%h want 0/0/0", if_inst, if_pc, if_pc4); end
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch();
    tick();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_err++; $display("FAIL basic_req: got req=%b addr=%h want 1/0", mem_req, mem_addr); end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    n_cmp++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_wait: got req=%b valid=%b want 0/0", mem_req, if_valid); end
    mem_rvalid = 1'b1; mem_rdata = 32'h2002_0005; tick(); mem_rvalid = 1'b0;
    n_cmp++; if (if_valid !== 1'b1 || if_inst !== 32'h2002_0005) begin
      n_err++; $display("FAIL basic_out: got valid=%b inst=%h want 1/20020005", if_valid, if_inst); end
    n_cmp++; if (if_pc !== 32'h0 || if_pc4 !== 32'h4 || mem_addr !== 32'h4) begin
      n_err++; $display("FAIL basic_pc: got pc=%h pc4=%h addr=%h want 0/4/4", if_pc, if_pc4, mem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (if_valid !== 1'b1 || if_inst !== 32'h2002_0005 || if_pc !== 32'h0 || mem_req !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d: got valid=%b inst=%h pc=%h req=%b want 1/20020005/0/0",
                          i, if_valid, if_inst, if_pc, mem_req); end
    end
    stall = 1'b0; tick();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h4 || if_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_release: got req=%b addr=%h valid=%b want 1/4/0", mem_req, mem_addr, if_valid); end
  endtask

  task automatic test_redirect_wait();
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h100; tick(); redirect = 1'b0;
    n_cmp++; if (mem_addr !== 32'h100 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL rdw_addr: got addr=%h req=%b want 100/0", mem_addr, mem_req); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick(); mem_rvalid = 1'b0;
    n_cmp++; if (if_valid !== 1'b0 || if_inst !== 32'h2002_0005) begin
      n_err++; $display("FAIL rdw_drop: got valid=%b inst=%h want 0/20020005", if_valid, if_inst); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      n_err++; $display("FAIL rdw_next: got req=%b addr=%h want 1/100", mem_req, mem_addr); end
  endtask

  task automatic test_delayed_gnt();
    tick();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      n_err++; $display("FAIL dg_c1: got req=%b addr=%h want 1/100", mem_req, mem_addr); end
    redirect = 1'b1; redirect_pc = 32'h43; tick(); redirect = 1'b0;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
      n_err++; $display("FAIL dg_redir: got req=%b addr=%h want 1/40", mem_req, mem_addr); end
    tick();
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 32'h40) begin
      n_err++; $display("FAIL dg_gnt: got req=%b addr=%h want 0/40", mem_req, mem_addr); end
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222; tick(); mem_rvalid = 1'b0;
    n_cmp++; if (if_valid !== 1'b1 || if_inst !== 32'h1111_2222 || if_pc !== 32'h40 || if_pc4 !== 32'h44) begin
      n_err++; $display("FAIL dg_out: got valid=%b inst=%h pc=%h pc4=%h want 1/11112222/40/44",
                        if_valid, if_inst, if_pc, if_pc4); end
  endtask

  task automatic test_redirect_stall_out();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; tick();
    stall = 1'b0; redirect = 1'b0;
    n_cmp++; if (if_valid !== 1'b0 || mem_addr !== 32'h80 || mem_req !== 1'b1) begin
      n_err++; $display("FAIL rso: got valid=%b addr=%h req=%b want 0/80/1", if_valid, mem_addr, mem_req); end
  endtask

  task automatic test_zero_latency();
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0033; tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    n_cmp++; if (if_valid !== 1'b1 || if_inst !== 32'h33 || if_pc !== 32'h80 || if_pc4 !== 32'h84) begin
      n_err++; $display("FAIL zl_out: got valid=%b inst=%h pc=%h pc4=%h want 1/33/80/84",
                        if_valid, if_inst, if_pc, if_pc4); end
    tick();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h84 || if_valid !== 1'b0) begin
      n_err++; $display("FAIL zl_next: got req=%b addr=%h valid=%b want 1/84/0", mem_req, mem_addr, if_valid); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; tick(); redirect = 1'b0;
    n_cmp++; if (mem_addr !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_align: got %h want fffffffc", mem_addr); end
    stall = 1'b1; mem_gnt = 1'b1; tick(); mem_gnt = 1'b0; stall = 1'b0;
    n_cmp++; if (mem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_err++; $display("FAIL wrap_wait: got req=%b valid=%b want 0/0", mem_req, if_valid); end
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0044; tick(); mem_rvalid = 1'b0;
    n_cmp++; if (if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'h0 || mem_addr !== 32'h0 || if_inst !== 32'h44) begin
      n_err++; $display("FAIL wrap_out: got pc=%h pc4=%h addr=%h inst=%h want fffffffc/0/0/44",
                        if_pc, if_pc4, mem_addr, if_inst); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    redirect = 1'b1; redirect_pc = 32'h200; tick(); redirect = 1'b0;
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    n_cmp++; if (mem_addr !== 32'h200 || mem_req !== 1'b0) begin
      n_err++; $display("FAIL rw_pre: got addr=%h req=%b want 200/0", mem_addr, mem_req); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (mem_addr !== 32'h0 || mem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0) begin
      n_err++; $display("FAIL rw_rst: got addr=%h req=%b valid=%b pc=%h want 0/0/0/0",
                        mem_addr, mem_req, if_valid, if_pc); end
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055; tick(); tick(); mem_rvalid = 1'b0;
    n_cmp++; if (if_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_err++; $display("FAIL rw_late: got valid=%b req=%b addr=%h want 0/1/0", if_valid, mem_req, mem_addr); end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0066; tick(); mem_rvalid = 1'b0;
    n_cmp++; if (if_valid !== 1'b1 || if_inst !== 32'h66 || if_pc !== 32'h0 || if_pc4 !== 32'h4) begin
      n_err++; $display("FAIL rw_after: got valid=%b inst=%h pc=%h pc4=%h want 1/66/0/4",
                        if_valid, if_inst, if_pc, if_pc4); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_delayed_gnt();
    test_redirect_stall_out();
    test_zero_latency();
    test_wrap();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Fetch sequencer for the 5-stage pipeline. It owns the PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake, so instruction memory may have variable latency.
- It delivers {instruction, pc, pc+4} to decode with a valid flag.
- It absorbs decode stalls (hazard) and EX-stage redirects (branch/jump target), including redirects that arrive while a memory request is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  decode hazard; hold current output
- redirect  in  1  EX requests PC change
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] are forced to 0 internally
- mem_req  out  1  instruction memory request
- mem_addr  out  ADDR_W  request address, word aligned
- mem_gnt  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  instruction word
- if_valid  out  1  decode output valid
- if_inst  out  32  fetched instruction
- if_pc  out  ADDR_W  PC of if_inst
- if_pc4  out  ADDR_W  if_pc + 4, modulo 2^ADDR_W

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, mem_req=0, mem_addr=RESET_PC, if_valid=0, if_inst=0, if_pc=0, if_pc4=0, discard=0.
  - rst mid-operation aborts everything immediately.
  - A late mem_rvalid for the aborted request is ignored.
  - Rule for the implementation: after reset, drop any rvalid seen before the first gnt.
- Outputs:
  - mem_addr = pc at all times.
  - mem_req = (state==REQ).
- FSM states:
  - IDLE: unconditionally go to REQ next cycle.
  - REQ: mem_req=1.
    - redirect and no gnt: pc<=redirect_pc; stay in REQ, so the new address is presented next cycle.
    - gnt & rvalid in the same cycle (zero-latency memory): capture as in WAIT below.
    - gnt only: go to WAIT. If redirect is asserted in the same cycle, set discard=1 and pc<=redirect_pc.
  - WAIT: wait for mem_rvalid.
    - redirect: discard<=1 and pc<=redirect_pc.
    - rvalid & discard: drop the data, clear discard, go to REQ.
    - rvalid & !discard & !redirect: if_inst<=mem_rdata, if_pc<=pc, if_pc4<=pc+4, pc<=pc+4, if_valid<=1, go to OUT.
    - rvalid & redirect in the same cycle: drop the data, pc<=redirect_pc, go to REQ.
  - OUT: if_valid=1.
    - redirect: if_valid<=0, pc<=redirect_pc, go to REQ. Redirect has priority over stall.
    - stall: hold all if_* outputs.
    - !stall: the word is consumed this cycle; if_valid<=0, go to REQ.
- Only one request is ever outstanding; mem_rvalid outside WAIT/REQ is ignored.
- Latency:
  - With single-cycle memory (gnt in REQ, rvalid next cycle), if_valid rises 2 cycles after entering REQ.
  - Throughput is 1 instruction per 3 cycles without stall.
- PC wrap: 32'hFFFF_FFFC + 4 = 0, with no flag.
- stall has no effect outside OUT.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds ports perf_fetch_cnt out 32 and perf_stall_cnt out 32.
  - perf_fetch_cnt increments on each OUT-to-REQ consumption without redirect.
  - perf_stall_cnt increments each cycle in OUT with stall & !redirect.
  - Both counters reset to 0 and wrap.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - typedef enum logic [1:0] fetch_state_t {IDLE, REQ, WAIT, OUT}
  - localparam INSN_W=32
  - localparam PC_STEP=4
- Sub-module fetch_perf_cnt: two 32-bit counters, instantiated only under FETCH_PERF_EN.

Test Plan:
- Reset, then memory with gnt immediate and rvalid 1 cycle later returning 0x2002_0005 -> mem_addr=0, if_valid on cycle 3, if_inst=0x2002_0005, if_pc=0, if_pc4=4; next mem_addr=4.
- Hold stall=1 for 4 cycles while in OUT -> if_* stable for 4 cycles, no mem_req; release -> mem_req with addr 4 next cycle.
- Redirect to 0x100 in WAIT, rvalid 2 cycles later with 0xDEAD_BEEF -> data never appears on if_inst; next mem_addr=0x100.
- gnt delayed 3 cycles, redirect to 0x43 in the second cycle of REQ -> mem_addr=0x40 from the next cycle; request granted at 0x40.
- redirect and stall in OUT in the same cycle with redirect_pc=0x80 -> if_valid=0 next cycle, mem_addr=0x80.
- pc=0xFFFF_FFFC fetch -> if_pc4=0, next mem_addr=0. rst asserted in WAIT with a late rvalid -> output stays invalid, mem_addr=RESET_PC.
